// File: rtl/layer_ram_stream.sv
// Layer memory with a single write port and a burst-read sequencer that streams a wrapping
// address range through a 2-entry output FIFO over a valid/ready handshake.
module layer_ram_stream #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 10,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_len,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_rd_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W:0]   L_DEPTH     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] L_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   L_CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] L_ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic              r_q_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issue_cnt;
  logic [ADDR_W:0]   r_beat_cnt;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_done;
  logic              r_err;

  logic w_pop;
  logic w_issue;
  logic w_last_beat;

  assign o_rd_valid  = (r_count != 2'd0);
  assign w_pop       = o_rd_valid & i_rd_ready;
  // Credit check: FIFO entries plus the read in flight, less this cycle's pop, must leave room.
  assign w_issue     = (r_state == S_STREAM) &&
                       (({1'b0, r_count} + {2'b00, r_q_valid}) < (3'd2 + {2'b00, w_pop}));
  assign w_last_beat = (r_beat_cnt == (r_len - L_CNT_ONE));
  assign o_rd_last   = o_rd_valid & w_last_beat;
  assign o_rd_data   = r_fifo[r_rd_ptr];
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;

  // Array is never reset; the registered read samples the old word on a same-edge write.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && ({1'b0, i_wr_addr} < L_DEPTH)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (w_issue) begin
      r_ram_q <= r_mem[r_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_q_valid   <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_q_valid <= w_issue;
      if (r_q_valid) begin
        r_fifo[r_wr_ptr] <= r_ram_q;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_beat_cnt <= r_beat_cnt + L_CNT_ONE;
      end
      r_count <= r_count + {1'b0, r_q_valid} - {1'b0, w_pop};

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              r_done <= 1'b1;
            end else if ((i_len > L_DEPTH) || ({1'b0, i_base_addr} >= L_DEPTH)) begin
              r_err <= 1'b1;
            end else begin
              r_addr      <= i_base_addr;
              r_len       <= i_len;
              r_issue_cnt <= '0;
              r_beat_cnt  <= '0;
              r_state     <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (w_issue) begin
            // Wrap on DEPTH-1 so non-power-of-two depths stream correctly.
            r_addr      <= (r_addr == L_LAST_ADDR) ? '0 : r_addr + L_ADDR_ONE;
            r_issue_cnt <= r_issue_cnt + L_CNT_ONE;
            if ((r_issue_cnt + L_CNT_ONE) == r_len) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last_beat) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_ram_stream.sv
// Randomised bench for layer_ram_stream: a plain array models the memory and every burst
// is expected to return mem[(base + k) mod DEPTH] for k = 0..len-1.
module tb_layer_ram_stream;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 784;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [DW-1:0] wr_data   = '0;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len_in    = '0;
  logic          rd_ready  = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  layer_ram_stream #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .i_base_addr(base_addr), .i_len(len_in),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
    .o_rd_last(rd_last), .o_busy(busy), .o_done(done), .o_err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap_data[$];
  bit            cap_last[$];
  int            cap_cycle[$];
  int            first_valid_c, done_c, done_cnt, err_cnt, stall_errs;
  bit            busy0;
  int            coll_c    = -1;
  logic [AW-1:0] coll_addr = '0;
  logic [DW-1:0] coll_data = '0;
  int            restart_c = -1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic write_word(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (addr < DEPTH) ref_mem[addr] = data;
  endtask

  task automatic build_expected(input int base, input int len);
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back(ref_mem[(base + k) % DEPTH]);
  endtask

  function automatic int first_diff();
    int n;
    n = (cap_data.size() < exp_q.size()) ? cap_data.size() : exp_q.size();
    for (int k = 0; k < n; k++) if (cap_data[k] !== exp_q[k]) return k;
    return (cap_data.size() == exp_q.size()) ? -1 : n;
  endfunction

  function automatic bit last_ok();
    int n;
    n = cap_last.size();
    if (n == 0) return 1'b0;
    for (int k = 0; k < n - 1; k++) if (cap_last[k]) return 1'b0;
    return cap_last[n-1];
  endfunction

  // Start a burst and observe it cycle by cycle; c = number of edges after the start edge.
  task automatic run_burst(input int base, input int len, input bit rnd, input int limit);
    bit            ready;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    cap_data.delete(); cap_last.delete(); cap_cycle.delete();
    first_valid_c = -1; done_c = -1; done_cnt = 0; err_cnt = 0; stall_errs = 0; busy0 = 1'b0;
    prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); len_in = (AW+1)'(len); rd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < limit; c++) begin
      wr_en = (c == coll_c);
      if (c == coll_c) begin wr_addr = coll_addr; wr_data = coll_data; end
      start = (c == restart_c);
      if (c == restart_c) begin base_addr = '0; len_in = (AW+1)'(2); end
      if (c == 0) busy0 = busy;
      if (err) err_cnt++;
      if (done) begin done_cnt++; if (done_c < 0) done_c = c; end
      if (rd_valid && first_valid_c < 0) first_valid_c = c;
      if (prev_stall && (!rd_valid || rd_data !== prev_data)) stall_errs++;
      ready = rnd ? ($urandom_range(0, 99) < 55) : 1'b1;
      rd_ready = ready;
      if (rd_valid && ready) begin
        cap_data.push_back(rd_data); cap_last.push_back(rd_last); cap_cycle.push_back(c);
      end
      prev_stall = rd_valid && !ready;
      prev_data  = rd_data;
      if (done_c >= 0 && c >= done_c + 2) break;
      @(posedge clk);
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0; rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b want 0", rd_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    rst_n = 1'b1;
    $display("reset: outputs checked at reset");
  endtask

  task automatic test_full_read();
    int d;
    for (int i = 0; i < DEPTH; i++) write_word(i, i[7:0]);
    build_expected(0, DEPTH);
    run_burst(0, DEPTH, 1'b0, DEPTH + 40);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL full_data: first diff beat %0d, got %0d beats want %0d", d, cap_data.size(), DEPTH); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1 after start edge", busy0); end
    checks++; if (first_valid_c != 2) begin errors++; $display("FAIL full_latency: got first valid at %0d want 2", first_valid_c); end
    checks++; if (!last_ok()) begin errors++; $display("FAIL full_last: got rd_last misplaced want only on beat %0d", DEPTH - 1); end
    checks++; if (done_c != DEPTH + 2) begin errors++; $display("FAIL full_done_time: got %0d want %0d", done_c, DEPTH + 2); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    checks++; if (cap_cycle.size() != DEPTH || cap_cycle[DEPTH-1] - cap_cycle[0] != DEPTH - 1) begin
      errors++; $display("FAIL full_gaps: got %0d beats with gaps want %0d contiguous", cap_cycle.size(), DEPTH);
    end
    $display("full_read: base 0 len %0d beats %0d done at %0d", DEPTH, cap_data.size(), done_c);
  endtask

  task automatic test_wrap();
    int d;
    for (int i = 0; i < 4; i++) write_word(780 + i, 8'($urandom_range(1, 255)));
    for (int i = 0; i < 4; i++) write_word(i, 8'($urandom_range(1, 255)));
    build_expected(780, 8);
    run_burst(780, 8, 1'b0, 40);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL wrap_data: first diff beat %0d, got %0d beats want 8", d, cap_data.size()); end
    checks++; if (!last_ok()) begin errors++; $display("FAIL wrap_last: got rd_last misplaced want only on beat 7"); end
    checks++; if (done_c != 10) begin errors++; $display("FAIL wrap_done_time: got %0d want 10", done_c); end
    $display("wrap: base 780 len 8 beats %0d", cap_data.size());
  endtask

  task automatic test_backpressure();
    int d, base, len;
    for (int it = 0; it < 4; it++) begin
      base = $urandom_range(0, DEPTH - 1);
      len  = (it == 0) ? 16 : $urandom_range(1, 40);
      build_expected(base, len);
      run_burst(base, len, 1'b1, 400);
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL bp_data: first diff beat %0d, got %0d beats want %0d", d, cap_data.size(), len); end
      checks++; if (stall_errs != 0) begin errors++; $display("FAIL bp_stall: got %0d unstable stalls want 0", stall_errs); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
      checks++; if (!last_ok()) begin errors++; $display("FAIL bp_last: got rd_last misplaced want only on final beat"); end
      $display("backpressure: base %0d len %0d beats %0d", base, len, cap_data.size());
    end
  endtask

  task automatic test_collision();
    int d;
    logic [DW-1:0] b3;
    write_word(103, 8'h11);
    build_expected(100, 8);
    coll_c = 3; coll_addr = AW'(103); coll_data = 8'hAA;
    run_burst(100, 8, 1'b0, 40);
    coll_c = -1;
    ref_mem[103] = 8'hAA;
    b3 = (cap_data.size() > 3) ? cap_data[3] : 'x;
    checks++; if (b3 !== 8'h11) begin errors++; $display("FAIL coll_old_word: got %h want 11", b3); end
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL coll_data: first diff beat %0d, got %0d beats want 8", d, cap_data.size()); end
    build_expected(103, 1);
    run_burst(103, 1, 1'b0, 20);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL coll_reread: got %0d beats, first diff %0d want AA", cap_data.size(), d); end
    $display("collision: beat3 %h reread %h", b3, (cap_data.size() > 0) ? cap_data[0] : 8'h00);
  endtask

  task automatic test_edge_lengths();
    run_burst(5, 0, 1'b0, 6);
    checks++; if (done_c != 0 || done_cnt != 1) begin errors++; $display("FAIL len0_done: got at %0d count %0d want at 0 count 1", done_c, done_cnt); end
    checks++; if (first_valid_c != -1 || busy0 !== 1'b0) begin errors++; $display("FAIL len0_quiet: got valid at %0d busy %b want none 0", first_valid_c, busy0); end
    run_burst(0, DEPTH + 1, 1'b0, 6);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL lenbig_err: got %0d err cycles want 1", err_cnt); end
    checks++; if (busy0 !== 1'b0 || done_cnt != 0 || first_valid_c != -1) begin
      errors++; $display("FAIL lenbig_quiet: got busy %b done %0d valid %0d want 0 0 -1", busy0, done_cnt, first_valid_c);
    end
    run_burst(800, 4, 1'b0, 6);
    checks++; if (err_cnt != 1 || busy0 !== 1'b0) begin errors++; $display("FAIL basebig_err: got err %0d busy %b want 1 0", err_cnt, busy0); end
    $display("edge_lengths: len0, len %0d, base 800 checked", DEPTH + 1);
  endtask

  task automatic test_start_while_busy();
    int d;
    build_expected(200, 10);
    restart_c = 3;
    run_burst(200, 10, 1'b0, 40);
    restart_c = -1;
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL busy_start_data: first diff beat %0d, got %0d beats want 10", d, cap_data.size()); end
    checks++; if (err_cnt != 0 || done_cnt != 1) begin errors++; $display("FAIL busy_start_flags: got err %0d done %0d want 0 1", err_cnt, done_cnt); end
    $display("start_while_busy: beats %0d", cap_data.size());
  endtask

  task automatic test_back_to_back();
    int guard, d;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(10); len_in = (AW+1)'(3); rd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 30) begin @(posedge clk); @(negedge clk); guard++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_a: got %b want 1 within 30 cycles", done); end
    start = 1'b1; base_addr = AW'(50); len_in = (AW+1)'(4);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
    cap_data.delete();
    guard = 0;
    while (cap_data.size() < 4 && guard < 30) begin
      if (rd_valid) cap_data.push_back(rd_data);
      @(posedge clk); @(negedge clk); guard++;
    end
    build_expected(50, 4);
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL b2b_data: first diff beat %0d, got %0d beats want 4", d, cap_data.size()); end
    guard = 0;
    while (!done && guard < 30) begin @(posedge clk); @(negedge clk); guard++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_b: got %b want 1 within 30 cycles", done); end
    $display("back_to_back: second burst beats %0d", cap_data.size());
  endtask

  task automatic test_reset_mid_burst();
    int beats, guard, bad, d;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(300); len_in = (AW+1)'(20); rd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    beats = 0; guard = 0;
    while (guard < 50) begin
      if (rd_valid) beats++;
      if (beats == 5) break;
      @(posedge clk); @(negedge clk); guard++;
    end
    checks++; if (beats != 5) begin errors++; $display("FAIL rst_reach5: got %0d beats want 5 within 50 cycles", beats); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rd_valid, rd_last, busy, done, err, rd_data} !== '0) begin
      errors++; $display("FAIL rst_async: got v%b l%b b%b d%b e%b data %h want all 0", rd_valid, rd_last, busy, done, err, rd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin @(negedge clk); if (rd_valid || done || busy || err) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles after release want 0", bad); end
    build_expected(300, 20);
    run_burst(300, 20, 1'b1, 200);
    d = first_diff();
    checks++; if (d != -1 || done_cnt != 1) begin errors++; $display("FAIL rst_reburst: diff beat %0d done %0d want -1 1", d, done_cnt); end
    $display("reset_mid_burst: reburst beats %0d", cap_data.size());
  endtask

  task automatic test_random();
    int d, base, len, addr;
    for (int it = 0; it < 5; it++) begin
      for (int w = 0; w < 4; w++) begin
        addr = $urandom_range(0, 1023);
        write_word(addr, 8'($urandom));
      end
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 60);
      build_expected(base, len);
      run_burst(base, len, 1'b1, 400);
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL rand_data: base %0d len %0d first diff %0d got %0d beats", base, len, d, cap_data.size()); end
      checks++; if (done_cnt != 1 || stall_errs != 0) begin errors++; $display("FAIL rand_flags: got done %0d stalls %0d want 1 0", done_cnt, stall_errs); end
      $display("random: base %0d len %0d beats %0d", base, len, cap_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_wrap();
    test_backpressure();
    test_collision();
    test_edge_lengths();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
